brew_sequencer: RTL

Top-level pouring sequencer for the pour-over brewer. It steps one brew cycle through pre-wet, bloom, main pour (spiral or one-spot), drain and done. It drives the 3-bit `pouring_state` bus consumed by the plate and crane motor controllers, the water-pump enable, and the crane motion command (steps, direction, restart). All durations count a slow `tick` enable pulse supplied by the clock divider.

---
 rtl/brew_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/brew_sequencer.sv
// Pour-over brew sequencer: walks pre-wet, bloom, main pour, drain and done,
// driving the pump and the crane sweep commands from a slow tick enable.
module brew_sequencer #(
  parameter int unsigned PREWET_TICKS   = 8,
  parameter int unsigned BLOOM_TICKS    = 30,
  parameter int unsigned POUR_TICKS     = 60,
  parameter int unsigned DRAIN_TICKS    = 20,
  parameter logic [11:0] STROKE_STEPS   = 12'd512,
  parameter int unsigned STROKE_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        abort,
  input  logic        brewing_path,
  input  logic        crane_equal,
  output logic [2:0]  pouring_state,
  output logic        water_pump,
  output logic [11:0] crane_steps,
  output logic        crane_dir,
  output logic        crane_go,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TW = 8;
  localparam int unsigned SW = 12;
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREWET   = 3'd1,
    S_BLOOM    = 3'd2,
    S_POUR     = 3'd3,
    S_ONE_SPOT = 3'd4,
    S_DRAIN    = 3'd5,
    S_DONE     = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] stroke_q, stroke_d;
  logic          path_q, path_d;
  logic          pour_met_q, pour_met_d;
  logic          go_prev_q;
  logic          pump_d, dir_d, go_d, busy_d, done_d;
  logic [SW-1:0] steps_d;
  logic          qual_equal, pour_exp, stroke_exp;

  // Next state and the registered output values it implies.
  always_comb begin
    state_d    = state_q;
    path_d     = path_q;
    pour_met_d = pour_met_q;
    dir_d      = crane_dir;
    go_d       = 1'b0;
    qual_equal = crane_equal && !crane_go && !go_prev_q;
    pour_exp   = tick && (timer_q == TW'(POUR_TICKS - 1));
    stroke_exp = tick && (stroke_q == TW'(STROKE_TIMEOUT - 1));

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_PREWET;
            path_d  = brewing_path;
          end
        end
        S_PREWET: if (tick && (timer_q == TW'(PREWET_TICKS - 1))) state_d = S_BLOOM;
        S_BLOOM: begin
          if (tick && (timer_q == TW'(BLOOM_TICKS - 1))) begin
            if (path_q) begin
              state_d = S_ONE_SPOT;
            end else begin
              state_d = S_POUR;
              go_d    = 1'b1;
              dir_d   = 1'b1;
            end
          end
        end
        S_POUR: begin
          if (pour_exp) pour_met_d = 1'b1;
          // Leave only once the minimum pour time is met and the crane is home.
          if (stroke_exp) begin
            state_d = S_FAULT;
          end else if (qual_equal) begin
            if (!crane_dir && (pour_met_q || pour_exp)) begin
              state_d = S_DRAIN;
            end else begin
              go_d  = 1'b1;
              dir_d = !crane_dir;
            end
          end
        end
        S_ONE_SPOT: if (pour_exp) state_d = S_DRAIN;
        S_DRAIN:    if (tick && (timer_q == TW'(DRAIN_TICKS - 1))) state_d = S_DONE;
        S_DONE:     state_d = S_IDLE;
        S_FAULT:    state_d = S_FAULT;
        default:    state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      timer_d    = '0;
      pour_met_d = 1'b0;
    end else if (tick && (timer_q != TMAX)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end

    if (go_d)                               stroke_d = '0;
    else if (tick && (stroke_q != TMAX))    stroke_d = stroke_q + TW'(1);
    else                                    stroke_d = stroke_q;

    if (state_d != S_POUR) dir_d = 1'b0;
    pump_d  = (state_d == S_PREWET) || (state_d == S_POUR) || (state_d == S_ONE_SPOT);
    steps_d = (state_d == S_POUR) ? STROKE_STEPS : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, timers and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      stroke_q    <= '0;
      path_q      <= 1'b0;
      pour_met_q  <= 1'b0;
      go_prev_q   <= 1'b0;
      water_pump  <= 1'b0;
      crane_steps <= '0;
      crane_dir   <= 1'b0;
      crane_go    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stroke_q    <= stroke_d;
      path_q      <= path_d;
      pour_met_q  <= pour_met_d;
      go_prev_q   <= crane_go;
      water_pump  <= pump_d;
      crane_steps <= steps_d;
      crane_dir   <= dir_d;
      crane_go    <= go_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  assign pouring_state = state_q;

endmodule
